uart_core_param: RTL and testbench

Parametrised full-duplex UART core: single-clock transmitter with a TX FIFO, 16x-oversampling receiver, and a shared runtime-programmable baud tick generator. Next-generation replacement for the fixed 8N1 UART top level, generalised in data width, stop bits, FIFO depth and divisor. Sits between the system bus glue (`wr_en`/`data_in`, `rdy`/`rdy_clr`) and the board `tx`/`rx` pins.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_tick.sv | 20 ++
 rtl/uart_core_param.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and oversampling constants shared by the UART core.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_PT  = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divisor counter, one-clock tick every baud_div+1 clocks.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);
  logic [DIV_WIDTH-1:0] r_cnt;

  // >= keeps the counter bounded if the divisor is lowered while it is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= '0;
    else if (r_cnt >= i_div) r_cnt <= '0;
    else                     r_cnt <= r_cnt + DIV_WIDTH'(1);
  end

  assign o_tick = (r_cnt == i_div);
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, TX FIFO + TX FSM, 16x-oversampled RX FSM, shared baud tick.
// Define UART_PARITY_EN to add a parity bit (polarity from parity_odd) to both directions.
module uart_core_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
`ifdef UART_PARITY_EN
  input  logic                 parity_odd,
`endif
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 full,
  output logic                 busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [AW:0]    PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]    PTR_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]     BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]     MID_LAST  = 5'(SAMPLE_PT - 1);
  localparam logic [4:0]     STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BW-1:0]  IDX_LAST  = BW'(DATA_BITS - 1);

  logic w_tick;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_div  (baud_div),
    .o_tick (w_tick)
  );

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]          w_count;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [DATA_BITS-1:0] w_fifo_rd;

  tx_state_t            r_tx_state;
  logic [4:0]           r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_tx;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == PTR_FULL);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_rd = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop     = !w_empty &&
                     ((r_tx_state == TX_IDLE) ||
                      (r_tx_state == TX_STOP && w_tick && r_tx_cnt == STOP_LAST));
  // a pop in the same cycle frees the slot, so a push at full is still accepted
  assign w_push    = wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
`ifdef UART_PARITY_EN
  logic r_tx_par;
  logic w_tx_par_nxt;
  assign w_tx_par_nxt = ^w_fifo_rd ^ parity_odd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_tx_sh    <= w_fifo_rd;
`ifdef UART_PARITY_EN
            r_tx_par   <= w_tx_par_nxt;
`endif
            r_tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (w_tick) begin
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (r_tx_cnt == BIT_LAST) begin
              r_tx_cnt   <= '0;
              r_tx_bit   <= '0;
              r_tx       <= r_tx_sh[0];
              r_tx_sh    <= r_tx_sh >> 1;
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_cnt <= r_tx_cnt + 5'd1;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_cnt == BIT_LAST) begin
              r_tx_cnt <= '0;
              if (r_tx_bit == IDX_LAST) begin
`ifdef UART_PARITY_EN
                r_tx       <= r_tx_par;
                r_tx_state <= TX_PARITY;
`else
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
`endif
              end else begin
                r_tx_bit <= r_tx_bit + BW'(1);
                r_tx     <= r_tx_sh[0];
                r_tx_sh  <= r_tx_sh >> 1;
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + 5'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            if (r_tx_cnt == BIT_LAST) begin
              r_tx_cnt   <= '0;
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_cnt <= r_tx_cnt + 5'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_cnt == STOP_LAST) begin
              r_tx_cnt <= '0;
              // next frame starts on this tick, so back-to-back frames have no idle gap
              if (w_pop) begin
                r_tx_sh    <= w_fifo_rd;
`ifdef UART_PARITY_EN
                r_tx_par   <= w_tx_par_nxt;
`endif
                r_tx       <= 1'b0;
                r_tx_state <= TX_START;
              end else begin
                r_tx_state <= TX_IDLE;
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + 5'd1;
            end
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign full = w_full;
  assign busy = !w_empty || (r_tx_state != TX_IDLE);

  // ---------------- RX ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t            r_rx_state;
  logic [4:0]           r_rx_cnt;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_sh;
  logic                 r_rdy, r_frame_err, r_overrun;
  logic [DATA_BITS-1:0] r_data_out;

`ifdef UART_PARITY_EN
  logic r_rx_par_bad, r_parity_err;
  logic w_rx_par_exp;
  assign w_rx_par_exp = ^r_rx_sh ^ parity_odd;
`endif

  // r_rx_s3 only feeds the falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rdy       <= 1'b0;
      r_data_out  <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (rdy_clr) begin
        r_rdy       <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_cnt == MID_LAST) begin
              r_rx_cnt <= '0;
              r_rx_bit <= '0;
              r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 5'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt <= '0;
              r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
              if (r_rx_bit == IDX_LAST) begin
`ifdef UART_PARITY_EN
                r_rx_state <= RX_PARITY;
`else
                r_rx_state <= RX_STOP;
`endif
              end else begin
                r_rx_bit <= r_rx_bit + BW'(1);
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + 5'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt   <= '0;
`ifdef UART_PARITY_EN
              r_rx_par_bad <= (r_rx_s2 != w_rx_par_exp);
`endif
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_cnt <= r_rx_cnt + 5'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_state <= RX_IDLE;
              // completion overrides a coincident rdy_clr
              if (!r_rdy || rdy_clr) begin
                r_data_out <= r_rx_sh;
                r_rdy      <= 1'b1;
              end else begin
                r_overrun  <= 1'b1;
              end
              if (!r_rx_s2) r_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              if (r_rx_par_bad) r_parity_err <= 1'b1;
`endif
            end else begin
              r_rx_cnt <= r_rx_cnt + 5'd1;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign data_out  = r_data_out;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed self-checking bench for uart_core_param (8 data bits, 1 stop, depth 16).
`timescale 1ns/1ps
module tb_uart_core_param;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        wr_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        full, busy, tx, rx, rdy;
  logic        rdy_clr = 1'b0;
  logic [7:0]  data_out;
  logic        frame_err, parity_err, overrun;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
`ifdef UART_PARITY_EN
  logic        parity_odd = 1'b0;
  logic        rx_par_flip = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_core_param #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
`ifdef UART_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .busy       (busy),
    .tx         (tx),
    .rx         (rx),
    .rdy_clr    (rdy_clr),
    .rdy        (rdy),
    .data_out   (data_out),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // independent frame decoder on the tx pin
  logic       mon_act = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'h00;
  int         mon_stop_bad = 0;
  int         mon_first = -1;
  logic [7:0] mon_q[$];

  always @(negedge clk) begin : mon
    int cn, bl, k;
    mon_prev <= tx;
    bl = 16 * (int'(baud_div) + 1);
    if (!mon_act) begin
      if (mon_prev && !tx) begin
        mon_act <= 1'b1;
        mon_cnt <= 0;
        if (mon_first < 0) mon_first <= cyc;
      end
    end else begin
      cn = mon_cnt + 1;
      mon_cnt <= cn;
      if (cn % bl == bl / 2) begin
        k = cn / bl;
        if (k >= 1 && k <= 8) mon_sh <= {tx, mon_sh[7:1]};
        if (k == NB - 1) begin
          if (!tx) mon_stop_bad <= mon_stop_bad + 1;
          mon_q.push_back(mon_sh);
          mon_act <= 1'b0;
        end
      end
    end
  end

  task automatic clear_rdy();
    @(posedge clk); #1 rdy_clr = 1'b1;
    @(posedge clk); #1 rdy_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_v);
    int bl;
    bl = 16 * (int'(baud_div) + 1);
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (bl) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bl) @(posedge clk);
      #1;
    end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ parity_odd ^ rx_par_flip;
    repeat (bl) @(posedge clk);
    #1;
`endif
    rx_drv = stop_v;
    repeat (bl) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (bl) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (rdy !== 1'b0)   begin bad++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if ({frame_err, parity_err, overrun} !== 3'b000)
      begin bad++; $display("FAIL reset_errs got=%b exp=000", {frame_err, parity_err, overrun}); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL post_reset_idle got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_tx_frame();
    int n;
    logic [NB-1:0] fr;
`ifdef UART_PARITY_EN
    fr = 11'b10101001010;
`else
    fr = 10'b1101001010;
`endif
    baud_div = 16'd3;
    repeat (4) @(posedge clk);
    #1 wr_en = 1'b1; data_in = 8'hA5;
    @(posedge clk); #1 wr_en = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tx_busy_rise got=%b exp=1", busy); end
    n = 0;
    while (tx !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n < 2 || n > 6) begin bad++; $display("FAIL tx_start_latency got=%0d exp=2..6", n); end
    repeat (32) @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) begin
      total++;
      if (tx !== fr[k]) begin bad++; $display("FAIL tx_bit%0d got=%b exp=%b", k, tx, fr[k]); end
      if (k < NB - 1) begin repeat (64) @(posedge clk); #1; end
    end
    repeat (31) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tx_busy_end_stop got=%b exp=1", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || tx !== 1'b1)
      begin bad++; $display("FAIL tx_busy_drop got busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    int t1, n;
    logic [7:0] got;
    baud_div = 16'd0;
    repeat (5) @(posedge clk);
    mon_q.delete();
    mon_first = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; data_in = 8'(16 + i);
      @(posedge clk); #1;
      if (i == 15) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL b2b_full_16 got=%b exp=0", full); end
      end
      if (i == 16) begin
        total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full_17 got=%b exp=1", full); end
      end
    end
    data_in = 8'hEE;
    @(posedge clk); #1 wr_en = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full_hold got=%b exp=1", full); end
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    t1 = cyc;
    total++; if (t1 - mon_first !== 17 * NB * 16)
      begin bad++; $display("FAIL b2b_duration got=%0d exp=%0d", t1 - mon_first, 17 * NB * 16); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (mon_q.size() !== 17) begin bad++; $display("FAIL b2b_count got=%0d exp=17", mon_q.size()); end
    for (int i = 0; i < 17; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 8'hXX;
      total++;
      if (got !== 8'(16 + i)) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, 8'(16 + i)); end
    end
    total++; if (mon_stop_bad !== 0) begin bad++; $display("FAIL b2b_stop got=%0d exp=0", mon_stop_bad); end
    total++; if (full !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL b2b_end got full=%b busy=%b exp 0 0", full, busy); end
  endtask

  task automatic test_loopback();
    int n;
    baud_div = 16'd3;
    loop_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 wr_en = 1'b1; data_in = 8'h3C;
    @(posedge clk); #1 wr_en = 1'b0;
    n = 0;
    while (rdy !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL loop_rdy got=%b exp=1", rdy); end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL loop_data got=%h exp=3c", data_out); end
    total++; if ({frame_err, parity_err, overrun} !== 3'b000)
      begin bad++; $display("FAIL loop_errs got=%b exp=000", {frame_err, parity_err, overrun}); end
    rdy_clr = 1'b1;
    @(posedge clk); #1 rdy_clr = 1'b0;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL loop_rdy_clr got=%b exp=0", rdy); end
    wait_idle(2000);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL loop_idle got=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'h11;
    @(posedge clk); #1 data_in = 8'h22;
    @(posedge clk); #1 wr_en = 1'b0;
    wait_idle(3000);
    repeat (20) @(posedge clk);
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ovr_rdy got=%b exp=1", rdy); end
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", data_out); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ovr_frame got=%b exp=0", frame_err); end
    clear_rdy();
    total++; if (overrun !== 1'b0 || rdy !== 1'b0)
      begin bad++; $display("FAIL ovr_clear got ovr=%b rdy=%b exp 0 0", overrun, rdy); end
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err();
    send_rx(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ferr_rdy got=%b exp=1", rdy); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL ferr_data got=%h exp=55", data_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ferr_ovr got=%b exp=0", overrun); end
    clear_rdy();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (16) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL glitch_rdy got=%b exp=0", rdy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b exp=0", frame_err); end
    send_rx(8'h96, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    total++; if (rdy !== 1'b1 || data_out !== 8'h96)
      begin bad++; $display("FAIL glitch_rearm got rdy=%b data=%h exp rdy=1 data=96", rdy, data_out); end
    clear_rdy();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    parity_odd = 1'b0;
    rx_par_flip = 1'b1;
    send_rx(8'h01, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_flag got=%b exp=1", parity_err); end
    total++; if (rdy !== 1'b1 || data_out !== 8'h01)
      begin bad++; $display("FAIL par_rdy got rdy=%b data=%h exp rdy=1 data=01", rdy, data_out); end
    rx_par_flip = 1'b0;
    clear_rdy();
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%b exp=0", parity_err); end
  endtask
`endif

  task automatic test_reset_mid_tx();
    int n, lows;
    baud_div = 16'd3;
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'h77;
    @(posedge clk); #1 data_in = 8'h88;
    @(posedge clk); #1 wr_en = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0 || full !== 1'b0)
      begin bad++; $display("FAIL rst_mid_busy got busy=%b full=%b exp 0 0", busy, full); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 800; i++) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
    total++; if (lows !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_fifo_lost got lows=%0d busy=%b exp lows=0 busy=0", lows, busy); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_loopback();
    test_overrun();
    test_frame_err();
    test_glitch();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
